ss_frame_decoder: RTL

SS_FRAME_DECODER -- requirements
Module: ss_frame_decoder

---
 rtl/ss_frame_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ss_frame_decoder.sv
// ss_frame_decoder: recovers the four digits shown on a multiplexed, active-low
// seven-segment display by watching its anode and cathode lines.
//
// Optional feature macro: SS_FRAME_DECODER_DP_CAPTURE_EN
//   defined   -> dp[n] captures the decimal point of digit n; bit 7 joins the
//                stability comparison.
//   undefined -> dp is held at 4'b0000 and SevenSegment[7] is ignored.
//
// Ports:
//   CLK100MHZ       in   sole clock, rising edge
//   Reset           in   asynchronous, active-high reset
//   SegmentDrivers  in   [3:0] anode enables, active-low, bit n = digit n
//   SevenSegment    in   [7:0] cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   digit3..digit0  out  [3:0] BCD of the last complete frame (F = unknown)
//   dp              out  [3:0] decimal points of the last frame, 1 = lit
//   frame_valid     out  one-cycle pulse when a frame is published
//   frame_err       out  published frame held an unrecognised pattern
//   timeout         out  one-cycle pulse when a partial frame is dropped
module ss_frame_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] SegmentDrivers,
    input  logic [7:0] SevenSegment,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] dp,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       timeout
);

`ifdef SS_FRAME_DECODER_DP_CAPTURE_EN
    localparam int unsigned SEG_W = 8;
`else
    localparam int unsigned SEG_W = 7;
`endif
    localparam int unsigned KEY_W = 4 + SEG_W;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_PRE  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       an_s1, an_s2;
    logic [7:0]       seg_s1, seg_s2;
    logic [KEY_W-1:0] prev_key;
    logic [CNT_W-1:0] stab_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       mask;
    logic             err_flag;
    logic [3:0]       shadow [4];
    logic [3:0]       shadow_dp;

    logic [KEY_W-1:0] key_c;
    logic             active_c, blank_c, same_c, accept_c;
    logic [1:0]       idx_c;
    logic [4:0]       dec_c;
    logic [3:0]       shadow_c [4];
    logic [3:0]       shadow_dp_c;
    logic [3:0]       mask_c;
    logic             err_c;

`ifndef SS_FRAME_DECODER_DP_CAPTURE_EN
    logic unused_dp_bit;
    assign unused_dp_bit = seg_s2[7] ^ ^shadow_dp_c;
`endif

    // Active-low pattern to {error, BCD}
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    // Sample classification and accept strobe
    always_comb begin
        key_c    = {an_s2, seg_s2[SEG_W-1:0]};
        active_c = $onehot(~an_s2);
        blank_c  = (seg_s2[6:0] == 7'h7F);
        same_c   = active_c && !blank_c && (key_c == prev_key);
        // Fires once: on the edge the counter would step onto its saturation value
        accept_c = same_c && (stab_cnt == STABLE_PRE);
        dec_c    = decode(seg_s2[6:0]);
        case (~an_s2)
            4'b0001: idx_c = 2'd0;
            4'b0010: idx_c = 2'd1;
            4'b0100: idx_c = 2'd2;
            default: idx_c = 2'd3;
        endcase
    end

    // Shadow/mask state including the digit being accepted this cycle
    always_comb begin
        shadow_c    = shadow;
        shadow_dp_c = shadow_dp;
        mask_c      = mask;
        err_c       = err_flag;
        if (accept_c) begin
            shadow_c[idx_c]    = dec_c[3:0];
            shadow_dp_c[idx_c] = ~seg_s2[7];
            mask_c[idx_c]      = 1'b1;
            err_c              = err_flag | dec_c[4];
        end
    end

    // Input synchroniser and stability tracking
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            an_s1    <= 4'hF;
            an_s2    <= 4'hF;
            seg_s1   <= 8'hFF;
            seg_s2   <= 8'hFF;
            prev_key <= '0;
            stab_cnt <= '0;
        end else begin
            an_s1    <= SegmentDrivers;
            an_s2    <= an_s1;
            seg_s1   <= SevenSegment;
            seg_s2   <= seg_s1;
            prev_key <= key_c;
            if (!same_c)
                stab_cnt <= '0;
            else if (stab_cnt != STABLE_LAST)
                stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    // Frame assembly, publication and timeout
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            shadow      <= '{default: 4'h0};
            shadow_dp   <= '0;
            mask        <= '0;
            err_flag    <= 1'b0;
            to_cnt      <= '0;
            digit3      <= '0;
            digit2      <= '0;
            digit1      <= '0;
            digit0      <= '0;
            dp          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            if (accept_c) begin
                // Accept wins over a coincident timeout
                to_cnt    <= '0;
                shadow    <= shadow_c;
                shadow_dp <= shadow_dp_c;
                if (mask_c == 4'hF) begin
                    digit3      <= shadow_c[3];
                    digit2      <= shadow_c[2];
                    digit1      <= shadow_c[1];
                    digit0      <= shadow_c[0];
`ifdef SS_FRAME_DECODER_DP_CAPTURE_EN
                    dp          <= shadow_dp_c;
`endif
                    frame_valid <= 1'b1;
                    frame_err   <= err_c;
                    mask        <= '0;
                    err_flag    <= 1'b0;
                end else begin
                    mask     <= mask_c;
                    err_flag <= err_c;
                end
            end else if (mask == 4'h0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt   <= '0;
                mask     <= '0;
                err_flag <= 1'b0;
                timeout  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule
